// File: rtl/servant_mgpio.sv
// Wishbone-attached GPIO block: output data with set/clear/toggle aliases, output enables,
// synchronized inputs and rising-edge interrupts with write-one-to-clear pending bits.
module servant_mgpio #(
  parameter int                   WIDTH       = 8,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]     RESET_VAL   = '0
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [2:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_oe,
  output logic             o_irq
);

  localparam logic [2:0] ADR_OUT  = 3'd0;
  localparam logic [2:0] ADR_SET  = 3'd1;
  localparam logic [2:0] ADR_CLR  = 3'd2;
  localparam logic [2:0] ADR_TGL  = 3'd3;
  localparam logic [2:0] ADR_OE   = 3'd4;
  localparam logic [2:0] ADR_IN   = 3'd5;
  localparam logic [2:0] ADR_IEN  = 3'd6;
  localparam logic [2:0] ADR_PEND = 3'd7;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] pend_clr;
  logic             ack_q, ack_d;
  logic [31:0]      rdt_q, rdt_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             rd_en;
  logic             unused_dat;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign unused_dat = ^i_wb_dat;
  assign wdat       = i_wb_dat[WIDTH-1:0];
  assign in_val     = sync_q[SYNC_STAGES-1];
  assign rise       = in_val & ~prev_q;
  // Every access (read or write) completes on the edge that raises ack.
  assign rd_en      = i_wb_cyc & ~ack_q;
  assign wr_en      = rd_en & i_wb_we;

  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    ien_d    = ien_q;
    pend_clr = '0;
    if (wr_en) begin
      case (i_wb_adr)
        ADR_OUT:  out_d    = wdat;
        ADR_SET:  out_d    = out_q | wdat;
        ADR_CLR:  out_d    = out_q & ~wdat;
        ADR_TGL:  out_d    = out_q ^ wdat;
        ADR_OE:   oe_d     = wdat;
        ADR_IEN:  ien_d    = wdat;
        ADR_PEND: pend_clr = wdat;
        default:  ;
      endcase
    end
    // Set beats clear when an edge and a W1C land on the same bit.
    pend_d = (pend_q & ~pend_clr) | (rise & ien_q);
    irq_d  = |(pend_q & ien_q);
    ack_d  = i_wb_cyc & ~ack_q;
    rdt_d  = '0;
    if (rd_en) begin
      case (i_wb_adr)
        ADR_OUT:  rdt_d = zext(out_q);
        ADR_OE:   rdt_d = zext(oe_q);
        ADR_IN:   rdt_d = zext(in_val);
        ADR_IEN:  rdt_d = zext(ien_q);
        ADR_PEND: rdt_d = zext(pend_q);
        default:  rdt_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      out_q  <= RESET_VAL;
      oe_q   <= '0;
      ien_q  <= '0;
      pend_q <= '0;
      prev_q <= '0;
      ack_q  <= 1'b0;
      rdt_q  <= '0;
      irq_q  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      ien_q     <= ien_d;
      pend_q    <= pend_d;
      prev_q    <= in_val;
      ack_q     <= ack_d;
      rdt_q     <= rdt_d;
      irq_q     <= irq_d;
      sync_q[0] <= i_gpio;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign o_gpio   = out_q;
  assign o_oe     = oe_q;
  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_irq    = irq_q;

endmodule

// File: tb/tb_servant_mgpio.sv
// Directed bench for servant_mgpio (WIDTH=8, SYNC_STAGES=2, RESET_VAL=0x11).
module tb_servant_mgpio;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       adr = '0;
  logic [31:0]      dat = '0;
  logic             we  = 1'b0;
  logic             cyc = 1'b0;
  logic [31:0]      rdt;
  logic             ack;
  logic [WIDTH-1:0] gpio_in = '0;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] oe;
  logic             irq;

  int checks = 0;
  int errors = 0;

  servant_mgpio #(.WIDTH(WIDTH), .SYNC_STAGES(2), .RESET_VAL(8'h11)) dut (
    .wb_clk(clk), .wb_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_we(we),
    .i_wb_cyc(cyc), .o_wb_rdt(rdt), .o_wb_ack(ack), .i_gpio(gpio_in),
    .o_gpio(gpio_out), .o_oe(oe), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // Caller is at a negedge; returns at a negedge one cycle after the ack cycle.
  task automatic bus(input logic [2:0] a, input logic [31:0] d, input logic w,
                     output logic [31:0] rd, output logic ack1, output logic ack2);
    adr = a; dat = d; we = w; cyc = 1'b1;
    @(negedge clk);
    ack1 = ack; rd = rdt;
    cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    ack2 = ack;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (gpio_out !== 8'h11) begin errors++; $display("FAIL rst_gpio got %h exp 11", gpio_out); end
    checks++; if (oe !== 8'h00) begin errors++; $display("FAIL rst_oe got %h exp 00", oe); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", ack); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    checks++; if (rdt !== 32'h0) begin errors++; $display("FAIL rst_rdt got %h exp 0", rdt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_out();
    logic [31:0] rd; logic a1, a2;
    logic [2:0]  adrs [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [7:0]  wv   [4] = '{8'hA5, 8'h0F, 8'h81, 8'hFF};
    logic [7:0]  ev   [4] = '{8'hA5, 8'hAF, 8'h2E, 8'hD1};
    for (int i = 0; i < 4; i++) begin
      bus(adrs[i], {24'h0, wv[i]}, 1'b1, rd, a1, a2);
      checks++; if (gpio_out !== ev[i]) begin errors++; $display("FAIL out_op%0d got %h exp %h", i, gpio_out, ev[i]); end
      checks++; if ({a1, a2} !== 2'b10) begin errors++; $display("FAIL out_ack%0d got %b exp 10", i, {a1, a2}); end
    end
    bus(3'd0, 32'hFFFF_FF5A, 1'b1, rd, a1, a2);
    bus(3'd0, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL out_upper got %h exp 0000005a", rd); end
  endtask

  task automatic test_oe_in();
    logic [31:0] rd; logic a1, a2;
    gpio_in = 8'h5A;
    repeat (3) @(negedge clk);
    bus(3'd4, 32'h0000_003C, 1'b1, rd, a1, a2);
    checks++; if (oe !== 8'h3C) begin errors++; $display("FAIL oe_pin got %h exp 3c", oe); end
    bus(3'd4, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0000_003C) begin errors++; $display("FAIL oe_read got %h exp 0000003c", rd); end
    bus(3'd5, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL in_read got %h exp 0000005a", rd); end
    bus(3'd1, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL set_read got %h exp 0", rd); end
    bus(3'd5, 32'h0000_00FF, 1'b1, rd, a1, a2);
    bus(3'd5, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL in_wr_ignored got %h exp 0000005a", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic a1, a2;
    gpio_in = 8'h00;
    repeat (4) @(negedge clk);
    bus(3'd6, 32'h0000_0001, 1'b1, rd, a1, a2);
    repeat (2) @(negedge clk);
    gpio_in = 8'h03;
    repeat (3) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_T3 got %b exp 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_T4 got %b exp 1", irq); end
    bus(3'd7, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL pend_masked got %h exp 00000001", rd); end
    bus(3'd5, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0000_0003) begin errors++; $display("FAIL in_after_edge got %h exp 00000003", rd); end
  endtask

  task automatic test_pend_race();
    logic [31:0] rd; logic a1, a2;
    gpio_in = 8'h02;
    repeat (4) @(negedge clk);
    gpio_in = 8'h03;
    repeat (2) @(negedge clk);
    bus(3'd7, 32'h0000_0001, 1'b1, rd, a1, a2);
    bus(3'd7, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL pend_set_wins got %h exp 00000001", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b exp 1", irq); end
    bus(3'd7, 32'h0000_0001, 1'b1, rd, a1, a2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got %b exp 0", irq); end
    bus(3'd7, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pend_cleared got %h exp 0", rd); end
    gpio_in = 8'h02;
    repeat (4) @(negedge clk);
    gpio_in = 8'h03;
    repeat (5) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_second got %b exp 1", irq); end
    bus(3'd6, 32'h0, 1'b1, rd, a1, a2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ien_mask got %b exp 0", irq); end
    bus(3'd7, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL pend_kept got %h exp 00000001", rd); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    logic       rd_ok;
    rd_ok = 1'b1;
    adr = 3'd5; we = 1'b0; cyc = 1'b1;
    #1 pat[5] = ack;
    for (int i = 4; i >= 0; i--) begin
      @(negedge clk);
      pat[i] = ack;
      if (ack && rdt !== 32'h0000_0003) rd_ok = 1'b0;
      if (!ack && rdt !== 32'h0) rd_ok = 1'b0;
    end
    cyc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pat !== 6'b010101) begin errors++; $display("FAIL b2b_ack got %b exp 010101", pat); end
    checks++; if (rd_ok !== 1'b1) begin errors++; $display("FAIL b2b_rdt got %b exp 1", rd_ok); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; logic a1, a2;
    bus(3'd4, 32'h0000_00FF, 1'b1, rd, a1, a2);
    bus(3'd6, 32'h0000_0001, 1'b1, rd, a1, a2);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_rst_irq got %b exp 1", irq); end
    adr = 3'd0; dat = 32'h0000_00EE; we = 1'b1; cyc = 1'b1; rst = 1'b1;
    @(negedge clk);
    checks++; if (gpio_out !== 8'h11) begin errors++; $display("FAIL mrst_gpio got %h exp 11", gpio_out); end
    checks++; if (oe !== 8'h00) begin errors++; $display("FAIL mrst_oe got %h exp 00", oe); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mrst_ack got %b exp 0", ack); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mrst_irq got %b exp 0", irq); end
    cyc = 1'b0; we = 1'b0; rst = 1'b0;
    @(negedge clk);
    bus(3'd0, 32'h0, 1'b0, rd, a1, a2);
    checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL mrst_out_read got %h exp 00000011", rd); end
    checks++; if (gpio_out !== 8'h11) begin errors++; $display("FAIL mrst_not_applied got %h exp 11", gpio_out); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_out();
    test_oe_in();
    test_irq();
    test_pend_race();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
